periph_bus_endpoint: RTL and testbench

//  Device-side endpoint directly downstream of the peripheral bus FSM. Claims transactions addressed
//  to its DEVICE_ID and executes read/write/clear on an 8x32 register bank (reg 7 = live status input).

---
 rtl/periph_bus_pkg.sv | 16 +
 rtl/periph_regbank.sv | 23 ++
 rtl/periph_bus_endpoint.sv | 95 +++++++++
 tb/tb_periph_bus_endpoint.sv | 135 +++++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared opcodes, state encoding and command layout for the peripheral bus endpoint
package periph_bus_pkg;
  localparam int DEV_W = 5;
  localparam logic [2:0] OP_READ = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b010;
  localparam logic [2:0] STATUS_IDX = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_ACK} state_e;
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] idx;
  } cmd_t;
  function automatic logic cmd_err(cmd_t c);
    return !(c.op inside {OP_READ, OP_WRITE, OP_CLEAR}) || (c.op == OP_WRITE && c.idx == STATUS_IDX);
  endfunction
endpackage

// File: rtl/periph_regbank.sv
// periph_regbank: seven 32-bit registers with write/clear port and a read mux exposing live status at index 7
module periph_regbank
  import periph_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [2:0]  wr_idx_i,
  input  logic [31:0] wr_data_i,
  input  logic        clr_i,
  input  logic [2:0]  rd_idx_i,
  input  logic [31:0] status_i,
  output logic [31:0] rd_data_o
);
  logic [31:0] regs_q [7];
  always_ff @(posedge clk or posedge reset) begin
    for (int i = 0; i < 7; i++)
      if (reset) regs_q[i] <= '0;
      else if (clr_i) regs_q[i] <= '0;
      else if (we_i && wr_idx_i == 3'(i)) regs_q[i] <= wr_data_i;
  end
  always_comb rd_data_o = (rd_idx_i == STATUS_IDX) ? status_i : regs_q[rd_idx_i];
endmodule

// File: rtl/periph_bus_endpoint.sv
// periph_bus_endpoint: claims bus transactions for DEVICE_ID and executes read/write/clear on the register bank
module periph_bus_endpoint
  import periph_bus_pkg::*;
#(
  parameter logic [DEV_W-1:0] DEVICE_ID = 5'd1,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bus_valid,
  input  logic [DEV_W-1:0] bus_device,
  input  logic [5:0]       bus_command,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_ack,
  output logic             bus_err,
  output logic             busy,
  output logic             dev_wr,
  output logic [2:0]       dev_wr_idx,
  output logic [31:0]      dev_wr_data,
  input  logic [31:0]      dev_status
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  cmd_t cmd_q, cmd_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, wr_data_q, wr_data_d, rd_data;
  logic ack_q, ack_d, err_q, err_d, wr_q, wr_d;
  logic [2:0] wr_idx_q, wr_idx_d;
  logic claim, exec, bad, ok_wr, hold;
  assign claim = bus_valid && bus_device == DEVICE_ID;
  assign exec = state_q == S_EXEC;
  assign bad = cmd_err(cmd_q);
  assign ok_wr = exec && cmd_q.op == OP_WRITE && !bad;
  assign hold = state_q == S_ACK && bus_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      cmd_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      wr_q <= 1'b0;
      wr_idx_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cmd_q <= cmd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q <= ack_d;
      err_q <= err_d;
      wr_q <= wr_d;
      wr_idx_q <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end
  always_comb begin
    state_d = state_q == S_IDLE ? (claim ? S_WAIT : S_IDLE) :
              state_q == S_WAIT ? (cnt_q == 4'(WAIT_STATES) ? S_EXEC : S_WAIT) :
              state_q == S_EXEC ? S_ACK :
              (bus_valid ? S_ACK : S_IDLE);
  end
  always_comb begin
    cnt_d = state_q == S_WAIT ? cnt_q + 4'd1 : '0;
    cmd_d = (state_q == S_IDLE && claim) ? cmd_t'(bus_command) : cmd_q;
    wdata_d = (state_q == S_IDLE && claim) ? bus_wdata : wdata_q;
    rdata_d = (exec && cmd_q.op == OP_READ) ? rd_data : rdata_q;
    ack_d = exec ? !bad : hold && ack_q;
    err_d = exec ? bad : hold && err_q;
    wr_d = ok_wr;
    wr_idx_d = ok_wr ? cmd_q.idx : wr_idx_q;
    wr_data_d = ok_wr ? wdata_q : wr_data_q;
  end
  periph_regbank u_regbank (
    .clk(clk),
    .reset(reset),
    .we_i(ok_wr),
    .wr_idx_i(cmd_q.idx),
    .wr_data_i(wdata_q),
    .clr_i(exec && cmd_q.op == OP_CLEAR),
    .rd_idx_i(cmd_q.idx),
    .status_i(dev_status),
    .rd_data_o(rd_data)
  );
  assign bus_rdata = rdata_q;
  assign bus_ack = ack_q;
  assign bus_err = err_q;
  assign busy = state_q != S_IDLE;
  assign dev_wr = wr_q;
  assign dev_wr_idx = wr_idx_q;
  assign dev_wr_data = wr_data_q;
endmodule

// File: tb/tb_periph_bus_endpoint.sv
// tb_periph_bus_endpoint: directed checks of claim, latency, read/write/clear, errors, reset abort and early valid drop
module tb_periph_bus_endpoint;
  logic clk = 1'b0, reset = 1'b1, bus_valid = 1'b0;
  logic [4:0] bus_device = '0;
  logic [5:0] bus_command = '0;
  logic [31:0] bus_wdata = '0, dev_status = '0;
  logic [31:0] bus_rdata, dev_wr_data;
  logic bus_ack, bus_err, busy, dev_wr;
  logic [2:0] dev_wr_idx;
  int total = 0, bad = 0;
  logic g_ack, g_err, g_wr, g_busy;
  logic [31:0] g_rd;
  int pulses;
  periph_bus_endpoint #(.DEVICE_ID(5'd1), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .bus_valid(bus_valid), .bus_device(bus_device),
    .bus_command(bus_command), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .busy(busy), .dev_wr(dev_wr),
    .dev_wr_idx(dev_wr_idx), .dev_wr_data(dev_wr_data), .dev_status(dev_status)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic [4:0] dev, input logic [5:0] cmd, input logic [31:0] wd);
    g_ack = 0; g_err = 0; g_wr = 0; g_busy = 0; g_rd = '0;
    bus_device = dev; bus_command = cmd; bus_wdata = wd; bus_valid = 1'b1;
    for (int i = 0; i < 20 && !(g_ack || g_err); i++) begin
      tick();
      g_ack = bus_ack; g_err = bus_err; g_wr |= dev_wr; g_busy |= busy; g_rd = bus_rdata;
    end
    bus_valid = 1'b0;
    tick();
  endtask
  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_ack", {bus_ack, bus_err, busy, dev_wr}, 0);
    chk("rst_wr_idx", {29'd0, dev_wr_idx}, 0);
    chk("rst_wr_data", dev_wr_data, 0);
    bus_device = 5'd1; bus_command = 6'b001011; bus_wdata = 32'hDEADBEEF; bus_valid = 1'b1;
    tick();
    chk("claim_busy", busy, 1);
    chk("claim_ack", bus_ack, 0);
    bus_command = 6'b111000; bus_wdata = 32'h0;
    tick(); tick(); tick();
    chk("lat3_ack", bus_ack, 0);
    tick();
    chk("lat4_ack", bus_ack, 1);
    chk("lat4_err", bus_err, 0);
    chk("wr_strobe", dev_wr, 1);
    chk("wr_idx", {29'd0, dev_wr_idx}, 3);
    chk("wr_data", dev_wr_data, 32'hDEADBEEF);
    tick();
    chk("ack_held", bus_ack, 1);
    chk("wr_one_cycle", dev_wr, 0);
    chk("busy_in_ack", busy, 1);
    bus_valid = 1'b0;
    tick();
    chk("ack_drop", bus_ack, 0);
    chk("busy_drop", busy, 0);
    xfer(5'd1, 6'b000011, 0);
    chk("rd3_ack", g_ack, 1);
    chk("rd3_data", g_rd, 32'hDEADBEEF);
    xfer(5'd9, 6'b001011, 32'h12345678);
    chk("other_dev_ack", {g_ack, g_err}, 0);
    chk("other_dev_busy", g_busy, 0);
    chk("other_dev_wr", g_wr, 0);
    xfer(5'd1, 6'b000011, 0);
    chk("rd3_unchanged", g_rd, 32'hDEADBEEF);
    dev_status = 32'h0000_00A5;
    xfer(5'd1, 6'b000111, 0);
    chk("rd7_ack", g_ack, 1);
    chk("rd7_data", g_rd, 32'hA5);
    xfer(5'd1, 6'b001111, 32'h1);
    chk("wr7_err", g_err, 1);
    chk("wr7_ack", g_ack, 0);
    chk("wr7_nowr", g_wr, 0);
    chk("rdata_kept", bus_rdata, 32'hA5);
    xfer(5'd1, 6'b111000, 0);
    chk("badop_err", {g_ack, g_err}, 1);
    for (int i = 0; i < 7; i++) xfer(5'd1, {3'b001, 3'(i)}, 32'h100 + i);
    xfer(5'd1, 6'b000101, 0);
    chk("rd5_pre_clear", g_rd, 32'h105);
    xfer(5'd1, 6'b010000, 0);
    chk("clear_ack", {g_ack, g_err}, 2);
    chk("clear_nowr", g_wr, 0);
    for (int i = 0; i < 7; i++) begin
      xfer(5'd1, {3'b000, 3'(i)}, 0);
      chk($sformatf("clr_rd%0d", i), g_rd, 0);
    end
    xfer(5'd1, 6'b001010, 32'h77);
    bus_command = 6'b001010; bus_wdata = 32'hCAFEF00D; bus_valid = 1'b1;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("arst_outs", {bus_ack, bus_err, busy, dev_wr}, 0);
    chk("arst_rdata", bus_rdata, 0);
    bus_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_no_ack", bus_ack, 0);
    end
    xfer(5'd1, 6'b000010, 0);
    chk("arst_reg2", g_rd, 0);
    xfer(5'd1, 6'b001010, 32'h0BADF00D);
    chk("post_rst_wr", {g_ack, g_wr}, 2'b11);
    xfer(5'd1, 6'b000010, 0);
    chk("post_rst_rd", g_rd, 32'h0BADF00D);
    bus_device = 5'd1; bus_command = 6'b001100; bus_wdata = 32'h5A5A5A5A; bus_valid = 1'b1;
    tick();
    bus_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(bus_ack);
    end
    chk("drop_pulses", pulses, 1);
    chk("drop_idle", busy, 0);
    xfer(5'd1, 6'b000100, 0);
    chk("drop_rd4", g_rd, 32'h5A5A5A5A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
